// File: rtl/ddr3_pkg.sv
// Shared DDR3 read-path constants and types.
// Used by the read unpacker and its FIFO.
package ddr3_pkg;

    localparam int DDR_DATA_W  = 128;
    localparam int PIX_W       = 16;
    localparam int LANES       = DDR_DATA_W / PIX_W;
    localparam int RFIFO_CNT_W = 11;

    typedef logic [$clog2(LANES)-1:0] lane_t;

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush.
// A push into a full FIFO is accepted only when a pop frees a slot.
module ddr3_sync_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr3_rd_unpacker.sv
// MIG read-data FIFO and 128-to-16 bit pixel unpacker with frame flush.
// Define RD_UNPACK_MSB_FIRST_EN to issue the most significant pixel first.
module ddr3_rd_unpacker #(
    parameter int DATA_W = ddr3_pkg::DDR_DATA_W,
    parameter int PIX_W  = ddr3_pkg::PIX_W,
    parameter int DEPTH  = 1024
) (
    input  logic                               ui_clk,
    input  logic                               ui_clk_sync_rst,
    input  logic [DATA_W-1:0]                  app_rd_data,
    input  logic                               app_rd_data_valid,
    input  logic                               rd_load,
    input  logic                               pix_rd_en,
    output logic [PIX_W-1:0]                   pix_data,
    output logic                               pix_valid,
    output logic [ddr3_pkg::RFIFO_CNT_W-1:0]   rfifo_wcount,
    output logic                               ovf_flag,
    output logic                               udf_flag
);

    import ddr3_pkg::*;

    localparam int    LANES_P = DATA_W / PIX_W;
    localparam int    CW      = $clog2(DEPTH) + 1;
    localparam lane_t LAST    = lane_t'(LANES_P - 1);

    logic              d0;
    logic              d1;
    logic              flush;
    logic              push;
    logic              pop;
    logic              fire;
    logic              full;
    logic              empty;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] head;
    logic [PIX_W-1:0]  slice;
    lane_t             lane;

    assign flush = d0 && !d1;
    assign push  = app_rd_data_valid && !flush;
    assign fire  = pix_rd_en && !empty && !flush;
    assign pop   = fire && (lane == LAST);

    assign rfifo_wcount = RFIFO_CNT_W'(cnt);

    always_comb begin
        slice = '0;
`ifdef RD_UNPACK_MSB_FIRST_EN
        slice = head[DATA_W-1-int'(lane)*PIX_W -: PIX_W];
`else
        slice = head[int'(lane)*PIX_W +: PIX_W];
`endif
    end

    ddr3_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (push),
        .din   (app_rd_data),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            d0 <= rd_load;
            d1 <= d0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            lane      <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            ovf_flag  <= 1'b0;
            udf_flag  <= 1'b0;
        end else begin
            pix_valid <= fire;
            if (fire) begin
                pix_data <= slice;
                lane     <= (lane == LAST) ? '0 : lane + 1'b1;
            end
            if (flush) begin
                lane     <= '0;
                ovf_flag <= 1'b0;
                udf_flag <= 1'b0;
            end else begin
                // A lane-7 pop in the same cycle makes room for the write.
                if (app_rd_data_valid && full && !pop)
                    ovf_flag <= 1'b1;
                if (pix_rd_en && empty)
                    udf_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rd_unpacker.sv
// Directed self-checking bench for ddr3_rd_unpacker.
// Define RD_UNPACK_MSB_FIRST_EN to check the MSB-first lane order.
module tb_ddr3_rd_unpacker;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic         din_v;
    logic         rd_load;
    logic         rd_en;
    logic [15:0]  pix;
    logic         pv;
    logic [10:0]  wcount;
    logic         ovf;
    logic         udf;

    int total = 0;
    int bad   = 0;

`ifdef RD_UNPACK_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    ddr3_rd_unpacker dut (
        .ui_clk            (clk),
        .ui_clk_sync_rst   (rst),
        .app_rd_data       (din),
        .app_rd_data_valid (din_v),
        .rd_load           (rd_load),
        .pix_rd_en         (rd_en),
        .pix_data          (pix),
        .pix_valid         (pv),
        .rfifo_wcount      (wcount),
        .ovf_flag          (ovf),
        .udf_flag          (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word w carries pixel value 16*w+j in bit position j*16.
    function automatic logic [127:0] mk(input int w);
        logic [127:0] r;
        for (int j = 0; j < 8; j++)
            r[j*16 +: 16] = 16'(16 * w + j);
        return r;
    endfunction

    // Expected k-th pixel issued from word mk(w).
    function automatic logic [31:0] ex(input int w, input int k);
        return 32'(16 * w + (MSB ? 7 - k : k));
    endfunction

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    logic [31:0] last;

    initial begin
        rst = 1'b1; din = '0; din_v = 1'b0; rd_load = 1'b0; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pv), 0);
        chk("rst_data", 32'(pix), 0);
        chk("rst_count", 32'(wcount), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_udf", 32'(udf), 0);
        rst = 1'b0;

        // write then drain one word
        din = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        din_v = 1'b1;
        step();
        din_v = 1'b0;
        chk("wr_count", 32'(wcount), 1);
        rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("drain_valid", 32'(pv), 1);
            chk("drain_data", 32'(pix), ex(0, k));
            chk("drain_count", 32'(wcount), (k < 7) ? 1 : 0);
        end
        rd_en = 1'b0;
        step();
        chk("drain_stop", 32'(pv), 0);
        chk("drain_hold", 32'(pix), ex(0, 7));

        // back-to-back words
        din_v = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            din = mk(w);
            step();
        end
        din_v = 1'b0;
        chk("b2b_count", 32'(wcount), 3);
        rd_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk("b2b_valid", 32'(pv), 1);
            chk("b2b_data", 32'(pix), ex(1 + i / 8, i % 8));
            chk("b2b_count", 32'(wcount), 32'(3 - (i + 1) / 8));
        end
        last = ex(3, 7);
        rd_en = 1'b0;
        step();

        // underflow
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("udf_valid", 32'(pv), 0);
        chk("udf_data", 32'(pix), last);
        chk("udf_flag", 32'(udf), 1);

        // five words, advance to lane 3; first pixel proves lane stayed 0
        din_v = 1'b1;
        for (int w = 4; w <= 8; w++) begin
            din = mk(w);
            step();
        end
        din_v = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_data", 32'(pix), ex(4, k));
        end
        rd_en = 1'b0;
        chk("pre_count", 32'(wcount), 5);

        // flush with write strobe high every cycle
        rd_load = 1'b1; din_v = 1'b1; din = mk(9);
        step();
        chk("fl_n_count", 32'(wcount), 6);
        chk("fl_n_udf", 32'(udf), 1);
        rd_en = 1'b1; din = mk(10);
        step();
        chk("fl_count", 32'(wcount), 0);
        chk("fl_udf", 32'(udf), 0);
        chk("fl_ovf", 32'(ovf), 0);
        chk("fl_valid", 32'(pv), 0);
        rd_en = 1'b0; din = mk(11);
        step();
        chk("fl_next", 32'(wcount), 1);
        din_v = 1'b0;
        step();
        chk("fl_held", 32'(wcount), 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fl_lane0_v", 32'(pv), 1);
        chk("fl_lane0_d", 32'(pix), ex(11, 0));

        // re-arm the edge detector and flush again
        rd_load = 1'b0;
        step();
        rd_load = 1'b1;
        step();
        chk("fl2_n", 32'(wcount), 1);
        step();
        chk("fl2_count", 32'(wcount), 0);
        rd_load = 1'b0;

        // fill past full
        din_v = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            din = rep(16'(i));
            step();
        end
        chk("full_count", 32'(wcount), 1024);
        chk("full_ovf0", 32'(ovf), 0);
        din = rep(16'hdead);
        step();
        din_v = 1'b0;
        chk("ovf_count", 32'(wcount), 1024);
        chk("ovf_flag", 32'(ovf), 1);

        // push and lane-7 pop together while full
        rd_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("f_pix", 32'(pix), 0);
        end
        din_v = 1'b1; din = rep(16'hbeef);
        step();
        din_v = 1'b0;
        chk("pp_count", 32'(wcount), 1024);
        chk("pp_pix", 32'(pix), 0);
        chk("pp_ovf", 32'(ovf), 1);

        // drain: words 1..1023 then the simultaneous word, no 0xdead
        for (int w = 1; w <= 1024; w++) begin
            for (int k = 0; k < 8; k++) begin
                step();
                chk("fd_valid", 32'(pv), 1);
                chk("fd_data", 32'(pix), (w == 1024) ? 32'hbeef : 32'(w));
            end
        end
        chk("fd_count", 32'(wcount), 0);
        step();
        rd_en = 1'b0;
        chk("fd_empty_v", 32'(pv), 0);
        chk("fd_udf", 32'(udf), 1);

        // reset mid-stream with MIG data in flight
        din_v = 1'b1; din = mk(5);
        step();
        din_v = 1'b0; rd_en = 1'b1;
        step();
        chk("mid_valid", 32'(pv), 1);
        rst = 1'b1; din_v = 1'b1;
        step();
        chk("mr_valid", 32'(pv), 0);
        chk("mr_data", 32'(pix), 0);
        chk("mr_count", 32'(wcount), 0);
        chk("mr_ovf", 32'(ovf), 0);
        chk("mr_udf", 32'(udf), 0);
        rst = 1'b0; din_v = 1'b0; rd_en = 1'b0;
        step();
        chk("mr_after", 32'(wcount), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
